// File: rtl/commit_trace_checker_pkg.sv
// Shared definitions for the commit trace checker: record layout, FSM
// state encodings and the field-masked record comparison.
package commit_trace_checker_pkg;

    localparam int REC_W = 55;

    // One committed instruction, MSB first:
    // {halt, reg_write, wr_reg, wr_data, mem_read, mem_write, addr, data}
    typedef struct packed {
        logic        halt;
        logic        reg_write;
        logic [2:0]  wr_reg;
        logic [15:0] wr_data;
        logic        mem_read;
        logic        mem_write;
        logic [15:0] addr;
        logic [15:0] data;
    } commit_rec_t;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DONE  = 2'd1;
    localparam logic [1:0] ST_ERROR = 2'd2;

    // Control bits are always compared. Register and memory payloads are only
    // compared when the golden record says that side effect happened, so junk
    // on unused buses never causes a false mismatch.
    function automatic logic rec_match(commit_rec_t obs, commit_rec_t gold);
        logic ok;
        ok = (obs.halt == gold.halt) && (obs.reg_write == gold.reg_write) &&
             (obs.mem_read == gold.mem_read) && (obs.mem_write == gold.mem_write);
        if (gold.reg_write)
            ok = ok && (obs.wr_reg == gold.wr_reg) && (obs.wr_data == gold.wr_data);
        if (gold.mem_read || gold.mem_write)
            ok = ok && (obs.addr == gold.addr) && (obs.data == gold.data);
        return ok;
    endfunction

endpackage

// File: rtl/commit_trace_checker_fifo.sv
// Synchronous FIFO buffering observed commits until the golden stream
// catches up. A push while full is accepted only when a pop frees the
// head slot in the same cycle; otherwise it is dropped.
module commit_trace_checker_fifo #(
    parameter int WIDTH = 55,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    // Storage array; contents are don't-care until written so it has no reset.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr[AW-1:0]] <= din;
    end

    // Read/write pointers with an extra wrap bit to tell full from empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/commit_trace_checker.sv
// In-simulation commit trace checker: buffers observed commits and compares
// them in order against golden records, flagging the first divergence,
// buffer overflow, or a successful halt.
module commit_trace_checker
    import commit_trace_checker_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             obs_reg_write,
    input  logic [2:0]       obs_wr_reg,
    input  logic [15:0]      obs_wr_data,
    input  logic             obs_mem_read,
    input  logic             obs_mem_write,
    input  logic [15:0]      obs_mem_addr,
    input  logic [15:0]      obs_mem_wdata,
    input  logic [15:0]      obs_mem_rdata,
    input  logic             obs_halt,
    input  logic             exp_valid,
    output logic             exp_ready,
    input  logic [REC_W-1:0] exp_rec,
    output logic             mismatch,
    output logic             overflow,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] commit_count,
    output logic [CNT_W-1:0] mismatch_index
);
    logic [1:0]  state;
    commit_rec_t obs_rec;
    commit_rec_t head_rec;
    logic [REC_W-1:0] head_bits;
    logic        obs_commit;
    logic        push;
    logic        pop;
    logic        full;
    logic        empty;
    logic        rec_ok;
    logic        overflow_event;

    assign obs_commit = obs_halt | obs_reg_write | obs_mem_read | obs_mem_write;
    assign obs_rec = '{halt:      obs_halt,
                       reg_write: obs_reg_write,
                       wr_reg:    obs_wr_reg,
                       wr_data:   obs_wr_data,
                       mem_read:  obs_mem_read,
                       mem_write: obs_mem_write,
                       addr:      obs_mem_addr,
                       data:      obs_mem_write ? obs_mem_wdata : obs_mem_rdata};

    assign push           = obs_commit && (state == ST_RUN);
    assign exp_ready      = (state == ST_RUN) && !empty;
    assign pop            = exp_valid && exp_ready;
    assign overflow_event = push && full && !pop;
    assign head_rec       = commit_rec_t'(head_bits);
    assign rec_ok         = rec_match(head_rec, commit_rec_t'(exp_rec));
    assign pass           = done && !mismatch && !overflow;

    commit_trace_checker_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (obs_rec),
        .dout  (head_bits),
        .full  (full),
        .empty (empty)
    );

    // Verdict FSM: each handshake either advances the match count or latches the first failure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_RUN;
            mismatch       <= 1'b0;
            overflow       <= 1'b0;
            done           <= 1'b0;
            commit_count   <= '0;
            mismatch_index <= '0;
        end else if (state == ST_RUN) begin
            if (pop) begin
                if (rec_ok) begin
                    commit_count <= commit_count + CNT_W'(1);
                    if (head_rec.halt) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end else begin
                    mismatch       <= 1'b1;
                    mismatch_index <= commit_count;
                    state          <= ST_ERROR;
                end
            end
            if (overflow_event) begin
                overflow <= 1'b1;
                state    <= ST_ERROR;
            end
        end
    end

endmodule

// File: tb/tb_commit_trace_checker.sv
// Directed self-checking bench for commit_trace_checker.
module tb_commit_trace_checker;

    logic        clk;
    logic        rst;
    logic        obs_reg_write;
    logic [2:0]  obs_wr_reg;
    logic [15:0] obs_wr_data;
    logic        obs_mem_read;
    logic        obs_mem_write;
    logic [15:0] obs_mem_addr;
    logic [15:0] obs_mem_wdata;
    logic [15:0] obs_mem_rdata;
    logic        obs_halt;
    logic        exp_valid;
    logic        exp_ready;
    logic [54:0] exp_rec;
    logic        mismatch;
    logic        overflow;
    logic        done;
    logic        pass;
    logic [31:0] commit_count;
    logic [31:0] mismatch_index;

    int checks = 0;
    int errors = 0;

    commit_trace_checker #(
        .FIFO_DEPTH (8),
        .CNT_W      (32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .obs_reg_write  (obs_reg_write),
        .obs_wr_reg     (obs_wr_reg),
        .obs_wr_data    (obs_wr_data),
        .obs_mem_read   (obs_mem_read),
        .obs_mem_write  (obs_mem_write),
        .obs_mem_addr   (obs_mem_addr),
        .obs_mem_wdata  (obs_mem_wdata),
        .obs_mem_rdata  (obs_mem_rdata),
        .obs_halt       (obs_halt),
        .exp_valid      (exp_valid),
        .exp_ready      (exp_ready),
        .exp_rec        (exp_rec),
        .mismatch       (mismatch),
        .overflow       (overflow),
        .done           (done),
        .pass           (pass),
        .commit_count   (commit_count),
        .mismatch_index (mismatch_index)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence wedges.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic clearObs();
        obs_halt      = 1'b0;
        obs_reg_write = 1'b0;
        obs_wr_reg    = 3'd0;
        obs_wr_data   = 16'h0;
        obs_mem_read  = 1'b0;
        obs_mem_write = 1'b0;
        obs_mem_addr  = 16'h0;
        obs_mem_wdata = 16'h0;
        obs_mem_rdata = 16'h0;
    endtask

    task automatic setObs(input logic h, input logic rw, input logic [2:0] r, input logic [15:0] wd,
                          input logic mr, input logic mw, input logic [15:0] a,
                          input logic [15:0] sdat, input logic [15:0] ldat);
        obs_halt      = h;
        obs_reg_write = rw;
        obs_wr_reg    = r;
        obs_wr_data   = wd;
        obs_mem_read  = mr;
        obs_mem_write = mw;
        obs_mem_addr  = a;
        obs_mem_wdata = sdat;
        obs_mem_rdata = ldat;
    endtask

    // Drive one observed commit for exactly one clock.
    task automatic applyStimulus(input logic h, input logic rw, input logic [2:0] r, input logic [15:0] wd,
                                 input logic mr, input logic mw, input logic [15:0] a,
                                 input logic [15:0] sdat, input logic [15:0] ldat);
        setObs(h, rw, r, wd, mr, mw, a, sdat, ldat);
        tick();
        clearObs();
    endtask

    function automatic logic [54:0] gold(input logic h, input logic rw, input logic [2:0] r,
                                         input logic [15:0] wd, input logic mr, input logic mw,
                                         input logic [15:0] a, input logic [15:0] d);
        return {h, rw, r, wd, mr, mw, a, d};
    endfunction

    // Offer one golden record and wait (bounded) for it to be consumed.
    task automatic sendGolden(input logic [54:0] rec);
        bit got;
        got       = 1'b0;
        exp_rec   = rec;
        exp_valid = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            if (exp_ready) got = 1'b1;
            tick();
        end
        exp_valid = 1'b0;
        checkOutput("handshake", {31'b0, got}, 32'd1);
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        exp_valid = 1'b0;
        exp_rec   = '0;
        clearObs();
        #3;
        checkOutput("rst_mismatch", {31'b0, mismatch}, 32'd0);
        checkOutput("rst_done", {31'b0, done}, 32'd0);
        checkOutput("rst_ready", {31'b0, exp_ready}, 32'd0);
        tick();
        tick();
        rst = 1'b0;

        // Test 1: commits then reset mid-run, then a clean three-write program with halt.
        applyStimulus(0, 1, 3'd7, 16'h7777, 0, 0, 16'h0, 16'h0, 16'h0);
        applyStimulus(0, 1, 3'd6, 16'h6666, 0, 0, 16'h0, 16'h0, 16'h0);
        checkOutput("t1_ready_before_rst", {31'b0, exp_ready}, 32'd1);
        doReset();
        checkOutput("t1_ready_after_rst", {31'b0, exp_ready}, 32'd0);
        applyStimulus(0, 1, 3'd1, 16'h0001, 0, 0, 16'h0, 16'h0, 16'h0);
        applyStimulus(0, 1, 3'd2, 16'h0002, 0, 0, 16'h0, 16'h0, 16'h0);
        applyStimulus(0, 1, 3'd3, 16'h0003, 0, 0, 16'h0, 16'h0, 16'h0);
        applyStimulus(1, 0, 3'd0, 16'h0, 0, 0, 16'h0, 16'h0, 16'h0);
        sendGolden(gold(0, 1, 3'd1, 16'h0001, 0, 0, 16'h0, 16'h0));
        sendGolden(gold(0, 1, 3'd2, 16'h0002, 0, 0, 16'h0, 16'h0));
        sendGolden(gold(0, 1, 3'd3, 16'h0003, 0, 0, 16'h0, 16'h0));
        checkOutput("t1_done_early", {31'b0, done}, 32'd0);
        sendGolden(gold(1, 0, 3'd0, 16'h0, 0, 0, 16'h0, 16'h0));
        checkOutput("t1_done", {31'b0, done}, 32'd1);
        checkOutput("t1_pass", {31'b0, pass}, 32'd1);
        checkOutput("t1_count", commit_count, 32'd4);
        checkOutput("t1_mismatch", {31'b0, mismatch}, 32'd0);

        // Test 2: store data differs by one bit from golden.
        doReset();
        applyStimulus(0, 0, 3'd0, 16'h0, 0, 1, 16'h0010, 16'hBEEF, 16'h0);
        checkOutput("t2_mismatch_pre", {31'b0, mismatch}, 32'd0);
        sendGolden(gold(0, 0, 3'd0, 16'h0, 0, 1, 16'h0010, 16'hBEEE));
        checkOutput("t2_mismatch", {31'b0, mismatch}, 32'd1);
        checkOutput("t2_index", mismatch_index, 32'd0);
        applyStimulus(0, 1, 3'd1, 16'h1111, 0, 0, 16'h0, 16'h0, 16'h0);
        checkOutput("t2_ready_after", {31'b0, exp_ready}, 32'd0);
        checkOutput("t2_pass", {31'b0, pass}, 32'd0);
        checkOutput("t2_count", commit_count, 32'd0);

        // Test 3: load with register writeback, then a load with junk register bus.
        doReset();
        applyStimulus(0, 1, 3'd4, 16'h1234, 1, 0, 16'h0020, 16'h0, 16'h1234);
        sendGolden(gold(0, 1, 3'd4, 16'h1234, 1, 0, 16'h0020, 16'h1234));
        checkOutput("t3_count1", commit_count, 32'd1);
        checkOutput("t3_mismatch1", {31'b0, mismatch}, 32'd0);
        applyStimulus(0, 0, 3'd5, 16'hDEAD, 1, 0, 16'h0022, 16'h0, 16'h5555);
        sendGolden(gold(0, 0, 3'd0, 16'h0000, 1, 0, 16'h0022, 16'h5555));
        checkOutput("t3_count2", commit_count, 32'd2);
        checkOutput("t3_mismatch2", {31'b0, mismatch}, 32'd0);

        // Test 4: nine commits with no golden stream overflow an 8-deep buffer.
        doReset();
        for (int k = 1; k <= 8; k++)
            applyStimulus(0, 1, 3'(k), 16'(k), 0, 0, 16'h0, 16'h0, 16'h0);
        checkOutput("t4_overflow_8", {31'b0, overflow}, 32'd0);
        applyStimulus(0, 1, 3'd1, 16'h0009, 0, 0, 16'h0, 16'h0, 16'h0);
        checkOutput("t4_overflow_9", {31'b0, overflow}, 32'd1);
        applyStimulus(1, 0, 3'd0, 16'h0, 0, 0, 16'h0, 16'h0, 16'h0);
        checkOutput("t4_pass", {31'b0, pass}, 32'd0);
        checkOutput("t4_done", {31'b0, done}, 32'd0);
        checkOutput("t4_ready", {31'b0, exp_ready}, 32'd0);

        // Test 5: full buffer with simultaneous push and pop is legal.
        doReset();
        for (int k = 1; k <= 8; k++)
            applyStimulus(0, 1, 3'(k), 16'(k), 0, 0, 16'h0, 16'h0, 16'h0);
        checkOutput("t5_ready_full", {31'b0, exp_ready}, 32'd1);
        setObs(1, 0, 3'd0, 16'h0, 0, 0, 16'h0, 16'h0, 16'h0);
        exp_rec   = gold(0, 1, 3'd1, 16'h0001, 0, 0, 16'h0, 16'h0);
        exp_valid = 1'b1;
        tick();
        exp_valid = 1'b0;
        clearObs();
        checkOutput("t5_overflow", {31'b0, overflow}, 32'd0);
        checkOutput("t5_count1", commit_count, 32'd1);
        for (int k = 2; k <= 8; k++)
            sendGolden(gold(0, 1, 3'(k), 16'(k), 0, 0, 16'h0, 16'h0));
        checkOutput("t5_count8", commit_count, 32'd8);
        sendGolden(gold(1, 0, 3'd0, 16'h0, 0, 0, 16'h0, 16'h0));
        checkOutput("t5_count9", commit_count, 32'd9);
        checkOutput("t5_pass", {31'b0, pass}, 32'd1);
        checkOutput("t5_mismatch", {31'b0, mismatch}, 32'd0);

        // Test 6: asynchronous reset with five records still buffered.
        doReset();
        for (int k = 1; k <= 6; k++)
            applyStimulus(0, 1, 3'(k), 16'(16'h0100 + k), 0, 0, 16'h0, 16'h0, 16'h0);
        sendGolden(gold(0, 1, 3'd1, 16'h0101, 0, 0, 16'h0, 16'h0));
        checkOutput("t6_count_pre", commit_count, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t6_async_count", commit_count, 32'd0);
        checkOutput("t6_async_ready", {31'b0, exp_ready}, 32'd0);
        checkOutput("t6_async_flags", {28'b0, mismatch, overflow, done, pass}, 32'd0);
        tick();
        rst = 1'b0;
        applyStimulus(0, 1, 3'd2, 16'hABCD, 0, 0, 16'h0, 16'h0, 16'h0);
        applyStimulus(1, 0, 3'd0, 16'h0, 0, 0, 16'h0, 16'h0, 16'h0);
        sendGolden(gold(0, 1, 3'd2, 16'hABCD, 0, 0, 16'h0, 16'h0));
        sendGolden(gold(1, 0, 3'd0, 16'h0, 0, 0, 16'h0, 16'h0));
        checkOutput("t6_count_post", commit_count, 32'd2);
        checkOutput("t6_pass", {31'b0, pass}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
